// File: rtl/axis_pkg.sv
// Shared AXI-Stream width-conversion helpers: default widths, a clog2 and the
// tkeep-to-final-lane mapping used by the down (and future up) converters.
package axis_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_OUT_WIDTH  = 8;
    localparam int MAX_LANES          = 64;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // tkeep is contiguous from lane 0; an empty mask still yields one lane.
    function automatic int keep_to_last_lane(input logic [MAX_LANES-1:0] keep,
                                             input int                   lanes);
        int count;
        count = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if ((i < lanes) && keep[i]) begin
                count = count + 1;
            end
        end
        return (count == 0) ? 0 : count - 1;
    endfunction

endpackage

// File: rtl/axis_width_down.sv
// AXI-Stream downsizer: buffers one DATA_WIDTH word and emits it as OUT_WIDTH
// beats, lane 0 first, with tlast on the final kept lane and zero-bubble reload.
module axis_width_down
    import axis_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int OUT_WIDTH  = DEFAULT_OUT_WIDTH,
    localparam int RATIO      = DATA_WIDTH / OUT_WIDTH,
    localparam int LANE_W     = (clog2(RATIO) < 1) ? 1 : clog2(RATIO)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [RATIO-1:0]      s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  last_q,      last_d;
    logic [LANE_W-1:0]     lane_cnt_q,  lane_cnt_d;
    logic [LANE_W-1:0]     last_lane_q, last_lane_d;

    logic                  at_last_lane;
    logic                  out_fire;
    logic                  final_fire;
    logic                  in_fire;
    logic [MAX_LANES-1:0]  keep_ext;

    assign at_last_lane  = (lane_cnt_q == last_lane_q);
    assign out_fire      = valid_q & m_axis_tready;
    assign final_fire    = out_fire & at_last_lane;
    // Ready depends only on held state and m_axis_tready, never on s_axis_tvalid.
    assign s_axis_tready = ~valid_q | final_fire;
    assign in_fire       = s_axis_tvalid & s_axis_tready;

    assign m_axis_tdata  = data_q[lane_cnt_q*OUT_WIDTH +: OUT_WIDTH];
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = valid_q & last_q & at_last_lane;

    always_comb begin
        keep_ext               = '0;
        keep_ext[RATIO-1:0]    = s_axis_tkeep;
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        lane_cnt_d  = lane_cnt_q;
        last_lane_d = last_lane_q;

        if (in_fire) begin
            data_d      = s_axis_tdata;
            valid_d     = 1'b1;
            last_d      = s_axis_tlast;
            lane_cnt_d  = '0;
            // Mid-packet words always carry every lane regardless of tkeep.
            last_lane_d = s_axis_tlast ? LANE_W'(keep_to_last_lane(keep_ext, RATIO))
                                       : LANE_W'(RATIO - 1);
        end else if (out_fire) begin
            if (at_last_lane) begin
                valid_d    = 1'b0;
                lane_cnt_d = '0;
            end else begin
                lane_cnt_d = lane_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            lane_cnt_q  <= '0;
            last_lane_q <= LANE_W'(RATIO - 1);
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            lane_cnt_q  <= lane_cnt_d;
            last_lane_q <= last_lane_d;
        end
    end

endmodule

// File: tb/tb_axis_width_down.sv
// Directed and randomised checks for the 32->8 AXI-Stream downsizer.
module tb_axis_width_down;

    logic        clk;
    logic        reset;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    int checks = 0;
    int passes = 0;

    logic [8:0] exp_q[$];

    axis_width_down #(
        .DATA_WIDTH(32),
        .OUT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs mid-cycle, then sample outputs before the next rising edge.
    task automatic cyc(input logic sv, input logic [31:0] sd, input logic [3:0] sk,
                       input logic sl, input logic mr, input logic rst_n,
                       output logic ov, output logic [7:0] od, output logic ol,
                       output logic sr);
        @(negedge clk);
        s_tvalid = sv;
        s_tdata  = sd;
        s_tkeep  = sk;
        s_tlast  = sl;
        m_tready = mr;
        reset    = rst_n;
        #1;
        ov = m_tvalid;
        od = m_tdata;
        ol = m_tlast;
        sr = s_tready;
    endtask

    task automatic test_reset();
        logic ov, ol, sr;
        logic [7:0] od;
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, ov, od, ol, sr);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, ov, od, ol, sr);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        checks++; if (ov !== 1'b0) $display("FAIL reset_tvalid got %b exp 0", ov); else passes++;
        checks++; if (ol !== 1'b0) $display("FAIL reset_tlast got %b exp 0", ol); else passes++;
        checks++; if (od !== 8'h00) $display("FAIL reset_tdata got %h exp 00", od); else passes++;
        checks++; if (sr !== 1'b1) $display("FAIL reset_s_tready got %b exp 1", sr); else passes++;
        $display("reset: done");
    endtask

    task automatic test_single_word();
        logic ov, ol, sr;
        logic [7:0] od;
        logic [7:0] exp_b [4];
        int low_cnt;
        exp_b   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        low_cnt = 0;
        cyc(1'b1, 32'hDDCCBBAA, 4'hF, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        checks++; if (sr !== 1'b1) $display("FAIL single_accept got %b exp 1", sr); else passes++;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
            checks++;
            if (ov !== 1'b1 || od !== exp_b[k] || ol !== 1'b0)
                $display("FAIL single_beat%0d got v=%b d=%h l=%b exp v=1 d=%h l=0", k, ov, od, ol, exp_b[k]);
            else passes++;
            if (sr === 1'b0) low_cnt++;
            $display("single: beat %0d data=%h last=%b", k, od, ol);
        end
        checks++; if (low_cnt != 3) $display("FAIL single_s_tready_low got %0d exp 3", low_cnt); else passes++;
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        checks++; if (ov !== 1'b0) $display("FAIL single_idle got %b exp 0", ov); else passes++;
    endtask

    task automatic test_back_to_back();
        logic ov, ol, sr, sv;
        logic [7:0] od;
        logic [31:0] sd;
        logic sl;
        logic [7:0] exp_b [8];
        int widx, beats, gaps;
        bit started;
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        widx = 0; beats = 0; gaps = 0; started = 0;
        for (int c = 0; c < 15; c++) begin
            sv = (widx < 2);
            sd = (widx == 0) ? 32'h44332211 : 32'h88776655;
            sl = (widx == 1);
            cyc(sv, sd, 4'hF, sl, 1'b1, 1'b1, ov, od, ol, sr);
            if (sv && sr) widx++;
            if (ov) begin
                started = 1;
                if (beats < 8) begin
                    checks++;
                    if (od !== exp_b[beats] || ol !== (beats == 7))
                        $display("FAIL b2b_beat%0d got d=%h l=%b exp d=%h l=%b", beats, od, ol, exp_b[beats], (beats == 7));
                    else passes++;
                end
                $display("b2b: beat %0d data=%h last=%b", beats, od, ol);
                beats++;
            end else if (started && beats < 8) begin
                gaps++;
            end
        end
        checks++; if (beats != 8) $display("FAIL b2b_count got %0d exp 8", beats); else passes++;
        checks++; if (gaps != 0) $display("FAIL b2b_gaps got %0d exp 0", gaps); else passes++;
    endtask

    task automatic test_short_last();
        logic ov, ol, sr, sv;
        logic [7:0] od;
        logic [31:0] sd;
        logic [3:0] sk;
        logic sl;
        logic [7:0] exp_b [7];
        logic       exp_l [7];
        int widx, beats, gaps;
        bit started;
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        widx = 0; beats = 0; gaps = 0; started = 0;
        for (int c = 0; c < 15; c++) begin
            sv = (widx < 2);
            sd = (widx == 0) ? 32'h00CCBBAA : 32'h44332211;
            sk = (widx == 0) ? 4'b0111 : 4'hF;
            sl = (widx == 0);
            cyc(sv, sd, sk, sl, 1'b1, 1'b1, ov, od, ol, sr);
            if (ov && beats == 2) begin
                checks++;
                if (sr !== 1'b1 || sv !== 1'b1)
                    $display("FAIL short_reload_on_cc got s_tready=%b exp 1", sr);
                else passes++;
            end
            if (sv && sr) widx++;
            if (ov) begin
                started = 1;
                if (beats < 7) begin
                    checks++;
                    if (od !== exp_b[beats] || ol !== exp_l[beats])
                        $display("FAIL short_beat%0d got d=%h l=%b exp d=%h l=%b", beats, od, ol, exp_b[beats], exp_l[beats]);
                    else passes++;
                end
                $display("short: beat %0d data=%h last=%b", beats, od, ol);
                beats++;
            end else if (started && beats < 7) begin
                gaps++;
            end
        end
        checks++; if (beats != 7) $display("FAIL short_count got %0d exp 7", beats); else passes++;
        checks++; if (gaps != 0) $display("FAIL short_gaps got %0d exp 0", gaps); else passes++;
    endtask

    task automatic test_mid_reset();
        logic ov, ol, sr;
        logic [7:0] od;
        logic [7:0] exp_b [4];
        exp_b = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        cyc(1'b1, 32'hDDCCBBAA, 4'hF, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        checks++; if (ov !== 1'b1 || od !== 8'hAA) $display("FAIL mid_beat0 got v=%b d=%h exp v=1 d=aa", ov, od); else passes++;
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        checks++; if (ov !== 1'b1 || od !== 8'hBB) $display("FAIL mid_beat1 got v=%b d=%h exp v=1 d=bb", ov, od); else passes++;
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, ov, od, ol, sr);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        checks++; if (ov !== 1'b0) $display("FAIL mid_flushed_tvalid got %b exp 0", ov); else passes++;
        checks++; if (sr !== 1'b1) $display("FAIL mid_flushed_s_tready got %b exp 1", sr); else passes++;
        $display("mid_reset: flushed v=%b s_tready=%b", ov, sr);
        cyc(1'b1, 32'h0D0C0B0A, 4'hF, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
            checks++;
            if (ov !== 1'b1 || od !== exp_b[k] || ol !== 1'b0)
                $display("FAIL mid_new_beat%0d got v=%b d=%h l=%b exp v=1 d=%h l=0", k, ov, od, ol, exp_b[k]);
            else passes++;
            $display("mid_reset: beat %0d data=%h", k, od);
        end
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        checks++; if (ov !== 1'b0) $display("FAIL mid_idle got %b exp 0", ov); else passes++;
    endtask

    task automatic test_zero_keep();
        logic ov, ol, sr;
        logic [7:0] od;
        cyc(1'b1, 32'h000000EE, 4'b0000, 1'b1, 1'b1, 1'b1, ov, od, ol, sr);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        checks++;
        if (ov !== 1'b1 || od !== 8'hEE || ol !== 1'b1)
            $display("FAIL zero_keep_beat got v=%b d=%h l=%b exp v=1 d=ee l=1", ov, od, ol);
        else passes++;
        $display("zero_keep: data=%h last=%b", od, ol);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, ov, od, ol, sr);
        checks++; if (ov !== 1'b0) $display("FAIL zero_keep_single got %b exp 0", ov); else passes++;
    endtask

    task automatic test_random();
        logic ov, ol, sr, sv, mr;
        logic [7:0] od;
        logic [31:0] wd;
        logic [3:0] wk;
        logic wl;
        logic prev_v, prev_r, prev_l;
        logic [7:0] prev_d;
        logic [8:0] e;
        bit have_word;
        int sent, got, nl, nk;
        have_word = 0; sent = 0; got = 0;
        prev_v = 0; prev_r = 1; prev_l = 0; prev_d = 0;
        wd = 0; wk = 0; wl = 0;
        exp_q.delete();
        for (int c = 0; c < 20000 && (sent < 200 || exp_q.size() > 0); c++) begin
            if (!have_word && sent < 200) begin
                wd = $urandom;
                wl = ($urandom_range(0, 3) == 0);
                nk = $urandom_range(0, 4);
                wk = 4'((5'd1 << nk) - 5'd1);
                have_word = 1;
            end
            sv = have_word && ($urandom_range(0, 9) < 7);
            mr = $urandom_range(0, 1);
            cyc(sv, wd, wk, wl, mr, 1'b1, ov, od, ol, sr);
            if (prev_v && !prev_r) begin
                checks++;
                if (ov !== 1'b1 || od !== prev_d || ol !== prev_l)
                    $display("FAIL rand_stall_stable got v=%b d=%h l=%b exp v=1 d=%h l=%b", ov, od, ol, prev_d, prev_l);
                else passes++;
            end
            if (ov && mr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra_beat got d=%h exp none", od);
                end else begin
                    e = exp_q.pop_front();
                    if (od !== e[7:0] || ol !== e[8])
                        $display("FAIL rand_beat%0d got d=%h l=%b exp d=%h l=%b", got, od, ol, e[7:0], e[8]);
                    else passes++;
                end
                got++;
            end
            if (sv && sr) begin
                nl = wl ? (($countones(wk) == 0) ? 1 : $countones(wk)) : 4;
                for (int i = 0; i < nl; i++)
                    exp_q.push_back({(wl && i == nl - 1), wd[8*i +: 8]});
                $display("random: word %0d data=%h keep=%b last=%b lanes=%0d", sent, wd, wk, wl, nl);
                have_word = 0;
                sent++;
            end
            prev_v = ov; prev_r = mr; prev_d = od; prev_l = ol;
        end
        checks++;
        if (sent != 200 || exp_q.size() != 0)
            $display("FAIL rand_complete got sent=%0d pending=%0d exp sent=200 pending=0", sent, exp_q.size());
        else passes++;
    endtask

    initial begin
        reset    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_short_last();
        test_mid_reset();
        test_zero_keep();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
